// File: rtl/count8_pkg.sv
// ---------------------------------------------------------------------------
// count8_pkg
// Shared definitions for the loadable 8-bit control counter.
//   WIDTH   : default counter/state width in bits
//   CNT_RST : value the counter returns to on reset
//   countOp : per-edge operation chosen by the next-state logic
// ---------------------------------------------------------------------------
package count8_pkg;

   localparam int WIDTH   = 8;
   localparam int CNT_RST = 0;

   typedef enum logic [1:0] {
      OP_HOLD = 2'd0,
      OP_INC  = 2'd1,
      OP_LOAD = 2'd2
   } countOp;

endpackage : count8_pkg

// File: rtl/count8_next.sv
// ---------------------------------------------------------------------------
// count8_next
// Purely combinational next-state function of the counter.
// Ports:
//   curState  [in]  present count (state register contents)
//   CNT_In    [in]  parallel-load value
//   EN        [in]  count enable
//   load      [in]  parallel-load request, higher priority than EN
//   nextState [out] state to be registered on the next rising edge
//   op        [out] decoded operation (HOLD / INC / LOAD)
// ---------------------------------------------------------------------------
module count8_next
   import count8_pkg::*;
#(
   parameter int WIDTH = count8_pkg::WIDTH
) (
   input  logic [WIDTH-1:0] curState,
   input  logic [WIDTH-1:0] CNT_In,
   input  logic             EN,
   input  logic             load,
   output logic [WIDTH-1:0] nextState,
   output countOp           op
);

   // Decode the operation first: load always wins over enable, and with
   // neither asserted the counter simply holds its value.
   always_comb begin
      op = OP_HOLD;
      if (load) begin
         op = OP_LOAD;
      end else if (EN) begin
         op = OP_INC;
      end
   end

   // Three-way source mux driven by the decoded operation. The increment
   // is truncated to WIDTH bits so 0xFF rolls over to 0x00 with no carry.
   always_comb begin
      nextState = curState;
      unique case (op)
         OP_LOAD: nextState = CNT_In;
         OP_INC:  nextState = curState + WIDTH'(1);
         default: nextState = curState;
      endcase
   end

endmodule : count8_next

// File: rtl/count8_ctrl.sv
// ---------------------------------------------------------------------------
// count8_ctrl
// Loadable, enable-gated up-counter built as an explicit next-state machine
// whose state register is the count itself.
// Ports:
//   clk    [in]  rising-edge clock
//   res    [in]  asynchronous active-high reset, clears the count
//   EN     [in]  count enable
//   load   [in]  synchronous parallel-load request (priority over EN)
//   CNT_In [in]  value captured when load=1
//   CNT    [out] current count, straight from the state register
// ---------------------------------------------------------------------------
module count8_ctrl
   import count8_pkg::*;
#(
   parameter int WIDTH = count8_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             res,
   input  logic             EN,
   input  logic             load,
   input  logic [WIDTH-1:0] CNT_In,
   output logic [WIDTH-1:0] CNT
);

   logic [WIDTH-1:0] nextState;
   countOp           curOp;

   count8_next #(
      .WIDTH (WIDTH)
   ) uNext (
      .curState  (CNT),
      .CNT_In    (CNT_In),
      .EN        (EN),
      .load      (load),
      .nextState (nextState),
      .op        (curOp)
   );

   // State register. Reset clears the count immediately and does not look
   // at any other input, so X on load/EN/CNT_In cannot leak out while res
   // is high. A HOLD cycle leaves the register untouched, which is the
   // same as reloading the current value.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         CNT <= WIDTH'(CNT_RST);
      end else if (curOp != OP_HOLD) begin
         CNT <= nextState;
      end
   end

endmodule : count8_ctrl

// File: tb/tb_count8_ctrl.sv
// ---------------------------------------------------------------------------
// tb_count8_ctrl
// Directed bench for count8_ctrl with a behavioural golden counter. Each
// clocked step computes the golden next value, queues it, and compares it
// with CNT shortly after the rising edge. Asynchronous behaviour (reset
// assertion/release between edges, mid-cycle input wiggles) is checked
// directly against constants or the golden value.
// ---------------------------------------------------------------------------
module tb_count8_ctrl;

   logic       clk;
   logic       res;
   logic       EN;
   logic       load;
   logic [7:0] CNT_In;
   logic [7:0] CNT;

   int         checks;
   int         errors;
   logic [7:0] goldCnt;
   logic [7:0] expQ[$];

   count8_ctrl #(
      .WIDTH (8)
   ) dut (
      .clk    (clk),
      .res    (res),
      .EN     (EN),
      .load   (load),
      .CNT_In (CNT_In),
      .CNT    (CNT)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global time limit so a broken design can never hang the run.
   initial begin
      #50000;
      $display("[TB] FAIL timeout: observed no finish, required finish before 50000");
      $fatal(1, "[TB] time limit expired");
   end

   // Compare CNT against an expected value computed by the bench.
   task automatic checkValue(input string tag, input logic [7:0] expected);
      checks++;
      assert (CNT === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, CNT, expected);
      end
   endtask

   // Pop the oldest scoreboard entry and compare it against CNT.
   task automatic checkOutput(input string tag);
      logic [7:0] expected;
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: observed empty scoreboard, required a queued value", tag);
      end else begin
         expected = expQ.pop_front();
         checkValue(tag, expected);
      end
   endtask

   // Drive one set of inputs for n rising edges. Before each edge the
   // golden counter is advanced and its value queued; 1 time unit after
   // the edge the queued value is popped and checked.
   task automatic applyStimulus(input logic r, input logic e, input logic l,
                                input logic [7:0] d, input int n,
                                input string tag);
      res    = r;
      EN     = e;
      load   = l;
      CNT_In = d;
      for (int i = 0; i < n; i++) begin
         if (r === 1'b1)      goldCnt = 8'h00;
         else if (l === 1'b1) goldCnt = d;
         else if (e === 1'b1) goldCnt = goldCnt + 8'h01;
         expQ.push_back(goldCnt);
         @(posedge clk);
         #1;
         checkOutput(tag);
      end
   endtask

   // Directed sequence.
   initial begin
      checks  = 0;
      errors  = 0;
      goldCnt = 8'h00;

      // Power-up reset: no clock edge needed.
      res    = 1'b1;
      EN     = 1'b1;
      load   = 1'b0;
      CNT_In = 8'h00;
      #1;
      checkValue("por_async", 8'h00);

      // Release reset before the first edge (t=5); count must not move.
      #2;
      res = 1'b0;
      #1;
      checkValue("por_release", 8'h00);

      // Count 0x01..0x04.
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 4, "count");

      // Load beats enable, held for two edges.
      applyStimulus(1'b0, 1'b1, 1'b1, 8'h11, 2, "load_prio");
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 3, "count_after_load");

      // Hold for five edges, then resume.
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 5, "hold");
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1, "resume");

      // Mid-cycle input changes must not reach CNT before an edge.
      load   = 1'b1;
      CNT_In = 8'h99;
      #2;
      checkValue("midcycle_load", goldCnt);
      load = 1'b0;

      // Load while disabled, then wrap through 0xFF.
      applyStimulus(1'b0, 1'b0, 1'b1, 8'hFE, 1, "load_disabled");
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 3, "wrap");

      // Async reset mid-operation.
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h37, 1, "load_37");
      #2;
      res = 1'b1;
      #1;
      goldCnt = 8'h00;
      checkValue("async_reset", 8'h00);

      // Edges during reset with load/EN active keep the count clear.
      applyStimulus(1'b1, 1'b1, 1'b1, 8'hAA, 2, "reset_over_load");
      applyStimulus(1'b1, 1'bx, 1'bx, 8'hxx, 2, "reset_with_x");

      // Release reset between edges, then count resumes from zero.
      EN     = 1'b1;
      load   = 1'b0;
      CNT_In = 8'h00;
      #2;
      res = 1'b0;
      #1;
      checkValue("reset_release", 8'h00);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 2, "count_after_reset");

      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard_drain: observed %0d leftover entries, required 0",
                  expQ.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_count8_ctrl
